// File: rtl/wb_regfile_write_arbiter.sv
// wb_regfile_write_arbiter
//
// Shares the single register-file write port between the pipeline
// write-back stage and the debug unit. A 1-entry skid buffer holds a
// pipeline write that a forced debug write displaced. The pipeline is
// stalled while that buffer is occupied. Writes to register 0 are
// suppressed (o_rf_we=0), but a debug write to register 0 is still acked.
//
// Grant priority, highest first:
//   buffer (if full)
//   forced debug (counter == MAX_WAIT)
//   pipeline
//   debug
//
// Latency: a write granted in cycle N appears on o_rf_* in cycle N+1.
//
// Optional build macro: WB_ARB_STATS_EN adds o_dbg_force_cnt and o_drop_err.
//
// Ports:
//   i_clock, i_reset         clock (rising edge), async active-low reset
//   i_wb_valid/addr/data     pipeline write-back request
//   i_dbg_req/addr/data      debug write request (level, held until ack)
//   o_dbg_ack                one-cycle pulse: debug write issued
//   o_pipe_stall             skid buffer occupied; pipeline must freeze
//   o_rf_we/addr/data        register-file write port
//   o_dbg_force_cnt          (stats) count of forced debug grants, saturating
//   o_drop_err               (stats) sticky: i_wb_valid seen while stalled
//
// Handshakes:
//   Debug is req/ack. The requester holds i_dbg_req with stable addr/data
//   until it sees o_dbg_ack, then drops or changes the request. A request
//   present while o_dbg_ack=1 is not eligible, so a lingering req is not
//   issued twice.
//   Pipeline has valid/stall semantics. i_wb_valid is ignored while
//   o_pipe_stall=1, and the pipeline re-presents its stage afterwards.
module wb_regfile_write_arbiter #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int MAX_WAIT = 4,
  parameter int NB_WAIT  = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_wb_valid,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_dbg_req,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_data,
  output logic               o_dbg_ack,
  output logic               o_pipe_stall,
  output logic               o_rf_we,
  output logic [NB_ADDR-1:0] o_rf_addr,
  output logic [NB_DATA-1:0] o_rf_data
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]        o_dbg_force_cnt,
  output logic               o_drop_err
`endif
);

  localparam logic [NB_WAIT-1:0] WAIT_LIMIT = NB_WAIT'(MAX_WAIT);

  // Skid buffer. o_pipe_stall doubles as the buffer-full flag.
  logic [NB_ADDR-1:0] buf_addr;
  logic [NB_DATA-1:0] buf_data;
  logic [NB_WAIT-1:0] wait_cnt;

  // Grant decode
  logic               dbg_elig;
  logic               forced;
  logic               gnt_buf;
  logic               gnt_dbg;
  logic               gnt_wb;
  logic               capture;
  logic               gnt_any;
  logic [NB_ADDR-1:0] nxt_addr;
  logic [NB_DATA-1:0] nxt_data;

  always_comb begin
    dbg_elig = i_dbg_req && !o_dbg_ack;
    forced   = 1'b0;
    gnt_buf  = 1'b0;
    gnt_dbg  = 1'b0;
    gnt_wb   = 1'b0;
    nxt_addr = o_rf_addr;
    nxt_data = o_rf_data;
    if (o_pipe_stall) begin
      gnt_buf  = 1'b1;
      nxt_addr = buf_addr;
      nxt_data = buf_data;
    end else if (dbg_elig && (wait_cnt == WAIT_LIMIT)) begin
      forced   = 1'b1;
      gnt_dbg  = 1'b1;
      nxt_addr = i_dbg_addr;
      nxt_data = i_dbg_data;
    end else if (i_wb_valid) begin
      gnt_wb   = 1'b1;
      nxt_addr = i_wb_addr;
      nxt_data = i_wb_data;
    end else if (dbg_elig) begin
      gnt_dbg  = 1'b1;
      nxt_addr = i_dbg_addr;
      nxt_data = i_dbg_data;
    end
    // A debug grant with a live pipeline request can only be the forced
    // case, and the buffer is empty whenever that branch is reached.
    capture = gnt_dbg && i_wb_valid;
    gnt_any = gnt_buf || gnt_dbg || gnt_wb;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_dbg_ack    <= 1'b0;
      o_pipe_stall <= 1'b0;
      o_rf_we      <= 1'b0;
      o_rf_addr    <= '0;
      o_rf_data    <= '0;
      buf_addr     <= '0;
      buf_data     <= '0;
      wait_cnt     <= '0;
    end else begin
      o_dbg_ack <= gnt_dbg;
      o_rf_we   <= gnt_any && (nxt_addr != '0);
      if (gnt_any) begin
        o_rf_addr <= nxt_addr;
        o_rf_data <= nxt_data;
      end

      if (capture) begin
        o_pipe_stall <= 1'b1;
        buf_addr     <= i_wb_addr;
        buf_data     <= i_wb_data;
      end else if (gnt_buf) begin
        o_pipe_stall <= 1'b0;
      end

      // Counts only cycles in which debug was eligible and lost.
      if (!i_dbg_req || gnt_dbg) begin
        wait_cnt <= '0;
      end else if (dbg_elig && (wait_cnt != WAIT_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_dbg_force_cnt <= '0;
      o_drop_err      <= 1'b0;
    end else begin
      if (forced && (o_dbg_force_cnt != 16'hFFFF)) begin
        o_dbg_force_cnt <= o_dbg_force_cnt + 16'd1;
      end
      if (i_wb_valid && o_pipe_stall) begin
        o_drop_err <= 1'b1;
      end
    end
  end
`endif

endmodule
